// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage handshake bundle between the pipeline and
// the iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 shift-add multiplier and restoring divider
// with private HI/LO, MADD/MSUB accumulate and cancel.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [1:0]       kind;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;

  logic             issue;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             is_div;
  logic             div_zero;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [W2-1:0]    res;

  assign issue = bus.start && !bus.op[3]
              && state == IDLE && !bus.cancel;
  assign bus.busy = issue || state != IDLE;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  // even op codes 0..7 are the signed variants
  assign neg_a = !bus.op[0] && bus.src_a[WIDTH-1];
  assign neg_b = !bus.op[0] && bus.src_b[WIDTH-1];
  assign mag_a = neg_a ? -bus.src_a : bus.src_a;
  assign mag_b = neg_b ? -bus.src_b : bus.src_b;

  assign is_div   = kind == 2'b01;
  assign div_zero = mcand == '0;

  assign add_sum = {1'b0, rem}
                 + (quo[0] ? {1'b0, mcand} : '0);
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};

  assign prod   = {rem, quo};
  assign prod_s = (sign_a ^ sign_b) ? -prod : prod;
  assign acc    = {hi_reg, lo_reg};
  assign q_s    = (sign_a ^ sign_b) ? -quo : quo;
  assign r_s    = sign_a ? -rem : rem;

  always_comb begin
    res = prod_s;
    unique case (1'b1)
      is_div && div_zero:  res = {a_raw, {WIDTH{1'b1}}};
      is_div && !div_zero: res = {r_s, q_s};
      kind == 2'b10:       res = acc + prod_s;
      kind == 2'b11:       res = acc - prod_s;
      default:             res = prod_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      kind     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      a_raw    <= '0;
      mcand    <= '0;
      quo      <= '0;
      rem      <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            if (!bus.op[3]) begin
              kind   <= bus.op[2:1];
              sign_a <= neg_a;
              sign_b <= neg_b;
              a_raw  <= bus.src_a;
              mcand  <= mag_b;
              quo    <= mag_a;
              rem    <= '0;
              count  <= CW'(WIDTH);
              state  <= CALC;
            end else if (bus.op == 4'd8) begin
              hi_reg <= bus.src_a;
            end else if (bus.op == 4'd9) begin
              lo_reg <= bus.src_a;
            end
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              // restore when the trial subtract goes negative
              if (diff[WIDTH]) begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
              end else begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
              end
            end else begin
              rem <= add_sum[WIDTH:1];
              quo <= {add_sum[0], quo[WIDTH-1:1]};
            end
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.cancel) begin
            hi_reg   <= res[W2-1:WIDTH];
            lo_reg   <= res[WIDTH-1:0];
            done_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with its own HI/LO registers, sitting in the EX stage beside the ALU. It replaces single-cycle behavioural `*`/`/` with a radix-2 shift-add multiplier and a restoring divider, one bit per cycle. It adds multiply-accumulate (MADD/MSUB), an explicit completion pulse and a cancel input for exception flushes. Operand width is a parameter.

## Interface
- WIDTH, 32, operand, HI and LO width; must be ≥ 4
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  issue the op on `op` this cycle; sampled only in IDLE
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10–15 are no-ops
- src_a  in  WIDTH  multiplicand/dividend, or MTHI/MTLO data
- src_b  in  WIDTH  multiplier/divisor
- cancel  in  1  abort the in-flight op; HI/LO are left unchanged
- busy  out  1  combinational stall request to the pipeline
- done  out  1  one-cycle pulse on the cycle after HI/LO commit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE + start, iterative op (0–7), no cancel:**
  - Latch src_a/src_b, op and the operand signs.
  - For signed ops, latch operand magnitudes.
  - Load counter = WIDTH; go to CALC.
- **IDLE + start, MTHI/MTLO:** write src_a to hi/lo at that edge. State stays IDLE; busy and done stay 0.
- **IDLE + start, op 10–15:** ignored.
- **start outside IDLE:** ignored; inputs are not re-latched.
- **CALC, multiply:** each cycle, add the shifted multiplicand if the current multiplier bit is 1, then shift.
- **CALC, divide:** each cycle, shift in the next dividend bit and trial-subtract the divisor. Restore on a negative result; the quotient bit is 1 otherwise.
- **CALC exit:** the counter decrements every cycle; at count 1, go to FIX.
- **FIX:**
  - Apply signs. Product sign = sign_a ^ sign_b; quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
  - MADD/MSUB: {hi,lo} ± product, computed modulo 2^(2·WIDTH) using the HI/LO values held at FIX.
  - MULT: {hi,lo} = 2·WIDTH-bit product.
  - DIV: lo = quotient, hi = remainder.
  - Commit hi/lo at the FIX edge; go to IDLE; done = 1 in the next cycle.
- **Divide by zero (DIV and DIVU):** lo = all ones, hi = src_a as latched. Sign correction is bypassed.
- **Signed MIN / −1:** lo = MIN, hi = 0. No trap.
- **cancel:**
  - In CALC or FIX: go to IDLE at the next edge; no commit, no done.
  - In IDLE with start: the start is suppressed, including MTHI/MTLO.
- **Reset (any state, including mid-op):** state = IDLE, hi = lo = 0, counter = 0, done = 0.
- **busy** = (start && op ≤ 7 && state == IDLE && !cancel) || state != IDLE.

## Timing
- **Reset values:** hi = 0, lo = 0, busy = 0, done = 0.
- **Start cycle:** start is sampled at edge E0; busy is already 1 during the start cycle itself.
- **CALC:** WIDTH cycles (E1..E_WIDTH).
- **FIX:** commits at edge E(WIDTH+1). The new hi/lo are visible from that edge.
- **Busy span:** WIDTH+2 cycles, including the start cycle. busy = 0 and done = 1 in the cycle after FIX.
- **Back-to-back:** a new start is allowed in the done cycle, since state is IDLE then.
- **Latency is identical for all ops 0–7.** For WIDTH = 32: busy for 34 cycles; done in cycle 35.
- **MTHI/MTLO:** zero-latency; the value is readable in the next cycle.
- **Stability:** src_a/src_b may change after E0 without effect on the result.

## Test plan
- **Signed multiply with sign fix:** reset, then MULT src_a = 0xFFFFFFFE (−2), src_b = 3 → at done, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. Busy is high for exactly 34 cycles.
- **Unsigned multiply, then accumulate:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Then MADDU 1 × 1 → lo = 0x00000002, hi unchanged.
- **Signed divide:** DIV −7 / 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- **Divide corner cases:**
  - DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Cancel mid-op:**
  - Set hi/lo via MTHI 0x1234 / MTLO 0x5678.
  - Start MULT 3 × 4; assert cancel at CALC cycle 10.
  - → busy drops the next cycle, no done, hi = 0x1234, lo = 0x5678.
  - A start issued mid-op is ignored.
- **Reset mid-op and re-issue:** assert reset during CALC → hi = lo = 0, busy = 0 next cycle. A MTLO issued with start in the same cycle as cancel is suppressed. WIDTH = 8 build: MULT 0x80 × 0x80 → {hi,lo} = 0x4000 after 10 busy cycles.
